// File: rtl/sw40g_pkg.sv
// Shared types and widths for the Sw_40g switch core.
package sw40g_pkg;

  localparam int unsigned SW_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_DRAIN
  } arb_state_t;

endpackage

// File: rtl/sw_rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr, with wrap.
module sw_rr_pick #(
  parameter  int unsigned N  = 7,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          grant_vld
);

  int unsigned idx;

  // Offset 1..N from ptr so the last winner has the lowest priority.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!grant_vld && req[PW'(idx)]) begin
        grant     = PW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_frame_rr_arbiter.sv
// Frame-level round-robin merge of N AXI-Stream ingress ports onto one egress stream,
// with tid stamping, oversize truncation and per-port frame/truncation counters.
module sw_frame_rr_arbiter
  import sw40g_pkg::*;
#(
  parameter  int unsigned N_PORTS   = 7,
  parameter  int unsigned DATA_W    = SW_DATA_W,
  parameter  int unsigned MAX_BEATS = 1024,
  parameter  int unsigned CNT_W     = 32,
  localparam int unsigned KEEP_W    = DATA_W / 8,
  localparam int unsigned TID_W     = $clog2(N_PORTS)
) (
  input  logic                              SysClk,
  input  logic                              Rst,
  input  logic [N_PORTS-1:0][DATA_W-1:0]    s_tdata,
  input  logic [N_PORTS-1:0][KEEP_W-1:0]    s_tkeep,
  input  logic [N_PORTS-1:0]                s_tvalid,
  input  logic [N_PORTS-1:0]                s_tlast,
  output logic [N_PORTS-1:0]                s_tready,
  output logic [DATA_W-1:0]                 m_tdata,
  output logic [KEEP_W-1:0]                 m_tkeep,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic [TID_W-1:0]                  m_tid,
  output logic                              m_tuser,
  input  logic                              m_tready,
  input  logic [N_PORTS-1:0]                cfg_port_en,
  output logic [N_PORTS-1:0][CNT_W-1:0]     stat_frames,
  output logic [N_PORTS-1:0][CNT_W-1:0]     stat_trunc
);

  localparam int unsigned BCNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BEATS - 1);

  arb_state_t         state_q, state_d;
  logic [TID_W-1:0]   grant_q, grant_d;
  logic [TID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [N_PORTS-1:0] req;
  logic [TID_W-1:0]   pick_grant;
  logic               pick_vld;
  logic               take, sel_valid, sel_last, at_limit;
  logic               out_load, frame_done, frame_trunc;

  assign req = s_tvalid & cfg_port_en;

  sw_rr_pick #(.N(N_PORTS)) u_pick (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .grant_vld (pick_vld)
  );

  // Next-state, ingress ready and per-beat strobes.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    s_tready    = '0;
    out_load    = 1'b0;
    frame_done  = 1'b0;
    frame_trunc = 1'b0;
    sel_valid   = s_tvalid[grant_q];
    sel_last    = s_tlast[grant_q];
    take        = !m_tvalid || m_tready;
    at_limit    = (beat_cnt_q == LAST_BEAT);

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d    = pick_grant;
          rr_ptr_d   = pick_grant;
          beat_cnt_d = '0;
          state_d    = ST_PASS;
        end
      end
      ST_PASS: begin
        s_tready[grant_q] = take;
        if (take && sel_valid) begin
          out_load   = 1'b1;
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (sel_last) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else if (at_limit) begin
            frame_trunc = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Tail of a truncated frame is swallowed up to its tlast.
        s_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= TID_W'(N_PORTS - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Egress register: loads on accepted beat, holds under backpressure.
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
      m_tid    <= '0;
    end else if (out_load) begin
      m_tdata  <= s_tdata[grant_q];
      m_tkeep  <= s_tkeep[grant_q];
      m_tvalid <= 1'b1;
      m_tlast  <= sel_last || at_limit;
      m_tuser  <= !sel_last && at_limit;
      m_tid    <= grant_q;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      stat_frames <= '0;
      stat_trunc  <= '0;
    end else begin
      if (frame_done) begin
        stat_frames[grant_q] <= stat_frames[grant_q] + CNT_W'(1);
      end
      if (frame_trunc) begin
        stat_trunc[grant_q] <= stat_trunc[grant_q] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sw_frame_rr_arbiter.sv
// Bench for sw_frame_rr_arbiter: per-port frame scoreboard fed from a frame-level model.
module tb_sw_frame_rr_arbiter;

  localparam int unsigned N  = 7;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = 8;
  localparam int unsigned MB = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned TW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic                     SysClk = 1'b0;
  logic                     Rst;
  logic [N-1:0][DW-1:0]     s_tdata;
  logic [N-1:0][KW-1:0]     s_tkeep;
  logic [N-1:0]             s_tvalid;
  logic [N-1:0]             s_tlast;
  logic [N-1:0]             s_tready;
  logic [DW-1:0]            m_tdata;
  logic [KW-1:0]            m_tkeep;
  logic                     m_tvalid;
  logic                     m_tlast;
  logic [TW-1:0]            m_tid;
  logic                     m_tuser;
  logic                     m_tready;
  logic [N-1:0]             cfg_port_en;
  logic [N-1:0][CW-1:0]     stat_frames;
  logic [N-1:0][CW-1:0]     stat_trunc;

  sw_frame_rr_arbiter #(.N_PORTS(N), .DATA_W(DW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
    .SysClk      (SysClk),
    .Rst         (Rst),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tid       (m_tid),
    .m_tuser     (m_tuser),
    .m_tready    (m_tready),
    .cfg_port_en (cfg_port_en),
    .stat_frames (stat_frames),
    .stat_trunc  (stat_trunc)
  );

  always #5 SysClk = ~SysClk;

  int          checks = 0;
  int          failures = 0;
  beat_t       drv_q [N][$];
  beat_t       exp_q [N][$];
  int unsigned exp_frames [N];
  int unsigned exp_trunc  [N];
  int          tid_log [$];
  int          mon_cnt = 0;
  int          cur_tid = 0;
  int          tready_mode = 0;
  bit          gaps = 1'b0;
  logic [N-1:0] fire_s;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a frame longer than MB leaves as its first MB beats, the last flagged bad.
  task automatic send_frame(input int p, input int len, input bit expect_it);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      b.last = (i == len - 1);
      b.user = 1'b0;
      drv_q[p].push_back(b);
      if (expect_it && i < int'(MB)) begin
        e      = b;
        e.last = (i == len - 1) || (i == int'(MB) - 1);
        e.user = (i == int'(MB) - 1) && (len > int'(MB));
        exp_q[p].push_back(e);
      end
    end
    if (expect_it) begin
      if (len > int'(MB)) exp_trunc[p]++;
      else                exp_frames[p]++;
    end
  endtask

  task automatic mon_beat();
    beat_t got, e;
    int t;
    t   = int'(m_tid);
    got = {m_tdata, m_tkeep, m_tlast, m_tuser};
    if (mon_cnt == 0) begin
      tid_log.push_back(t);
      cur_tid = t;
    end else begin
      chk("no_interleave_tid", 128'(t), 128'(cur_tid));
    end
    checks++;
    assert (t < int'(N) && exp_q[t].size() > 0) else begin
      failures++;
      $error("FAIL sb_unexpected_beat observed_tid=%0d data=%0h expected=none", t, m_tdata);
    end
    if (t < int'(N) && exp_q[t].size() > 0) begin
      e = exp_q[t].pop_front();
      chk("sb_beat", 128'(got), 128'(e));
    end
    mon_cnt = m_tlast ? 0 : mon_cnt + 1;
  endtask

  function automatic bit all_idle(input logic [N-1:0] mask);
    bit ok = !m_tvalid;
    for (int p = 0; p < int'(N); p++) begin
      if (exp_q[p].size() != 0) ok = 1'b0;
      if (mask[p] && drv_q[p].size() != 0) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic wait_drain(input string tag, input int budget, input logic [N-1:0] mask);
    int n = 0;
    while (n < budget && !all_idle(mask)) begin
      @(posedge SysClk); #3;
      n++;
    end
    chk(tag, 128'(n < budget), 128'(1));
  endtask

  task automatic chk_counters(input string tag);
    for (int p = 0; p < int'(N); p++) begin
      chk({tag, "_frames"}, 128'(stat_frames[p]), 128'(exp_frames[p]));
      chk({tag, "_trunc"},  128'(stat_trunc[p]),  128'(exp_trunc[p]));
    end
  endtask

  task automatic cycle();
    @(posedge SysClk); #3;
  endtask

  // Ingress drivers and egress monitor; handshakes sampled at the falling edge.
  initial begin : drive_mon
    beat_t b;
    forever begin
      @(negedge SysClk);
      fire_s = s_tvalid & s_tready;
      if (!Rst && m_tvalid && m_tready) mon_beat();
      @(posedge SysClk);
      #1;
      for (int p = 0; p < int'(N); p++) begin
        if (fire_s[p] && drv_q[p].size() > 0) b = drv_q[p].pop_front();
        if (!(s_tvalid[p] && !fire_s[p] && drv_q[p].size() > 0)) begin
          if (drv_q[p].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            s_tvalid[p] = 1'b1;
            s_tdata[p]  = drv_q[p][0].data;
            s_tkeep[p]  = drv_q[p][0].keep;
            s_tlast[p]  = drv_q[p][0].last;
          end else begin
            s_tvalid[p] = 1'b0;
          end
        end
      end
      case (tready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = !m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int ord [3];
    int found;
    ord = '{0, 3, 6};
    Rst = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    m_tready = 1'b1;
    cfg_port_en = '1;
    for (int p = 0; p < int'(N); p++) begin
      exp_frames[p] = 0;
      exp_trunc[p]  = 0;
    end
    #1;
    chk("rst_assert_outputs", 128'({s_tready, m_tvalid, m_tlast, m_tuser, m_tid}), 128'(0));
    repeat (3) @(posedge SysClk);
    #3 Rst = 1'b0;

    // Idle after reset: nothing granted, nothing counted.
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("rst_idle_outputs", 128'({s_tready, m_tvalid, m_tlast, m_tuser, m_tid, m_tkeep, m_tdata}), 128'(0));
      chk("rst_idle_counters", 128'((|stat_frames) | (|stat_trunc)), 128'(0));
    end

    // Three continuous requesters: strict 0,3,6 rotation.
    tid_log.delete();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) send_frame(ord[j], 4, 1'b1);
    wait_drain("rr_drain", 600, '1);
    chk("rr_frame_count", 128'(tid_log.size()), 128'(9));
    for (int i = 0; i < tid_log.size(); i++) chk("rr_order", 128'(tid_log[i]), 128'(ord[i % 3]));
    chk_counters("rr_cnt");

    // Oversize frame truncated, then an exactly-MB frame passes clean.
    send_frame(2, 12, 1'b1);
    send_frame(2, 8, 1'b1);
    wait_drain("trunc_drain", 300, '1);
    chk("trunc_stat", 128'(stat_trunc[2]), 128'(1));
    chk_counters("trunc_cnt");

    // Alternating egress backpressure.
    tready_mode = 1;
    send_frame(1, 5, 1'b1);
    wait_drain("bp_drain", 300, '1);
    tready_mode = 0;
    chk_counters("bp_cnt");

    // Random traffic, random gaps and backpressure.
    tready_mode = 2;
    gaps = 1'b1;
    for (int k = 0; k < 40; k++) send_frame($urandom_range(0, N - 1), $urandom_range(1, 12), 1'b1);
    wait_drain("rand_drain", 8000, '1);
    chk_counters("rand_cnt");
    tready_mode = 0;
    gaps = 1'b0;
    repeat (3) cycle();

    // Disable port 1 mid-frame: current frame finishes, later frames stay parked.
    send_frame(1, 6, 1'b1);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cycle();
      if (mon_cnt >= 2 && cur_tid == 1) found = 1;
    end
    chk("en_midframe_seen", 128'(found), 128'(1));
    cfg_port_en[1] = 1'b0;
    send_frame(1, 4, 1'b0);
    send_frame(1, 3, 1'b0);
    send_frame(4, 4, 1'b1);
    send_frame(4, 4, 1'b1);
    wait_drain("en_drain", 400, 7'b1111101);
    repeat (30) cycle();
    chk("en_port1_parked", 128'(drv_q[1].size()), 128'(7));
    chk("en_port1_ready", 128'(s_tready[1]), 128'(0));
    chk_counters("en_cnt");
    drv_q[1].delete();
    s_tvalid[1] = 1'b0;
    cfg_port_en = '1;
    repeat (3) cycle();

    // Reset during beat 3 of a 6-beat frame, then a fresh frame.
    send_frame(0, 6, 1'b1);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cycle();
      if (mon_cnt == 3 && cur_tid == 0) found = 1;
    end
    chk("rst_mid_seen", 128'(found), 128'(1));
    Rst = 1'b1;
    #1;
    chk("rst_mid_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_mid_tready", 128'(s_tready), 128'(0));
    for (int p = 0; p < int'(N); p++) begin
      drv_q[p].delete();
      exp_q[p].delete();
      exp_frames[p] = 0;
      exp_trunc[p]  = 0;
    end
    s_tvalid = '0;
    mon_cnt = 0;
    tid_log.delete();
    repeat (2) cycle();
    Rst = 1'b0;
    cycle();
    chk_counters("rst_mid_cnt");
    send_frame(0, 6, 1'b1);
    wait_drain("rst_fresh_drain", 200, '1);
    chk("rst_fresh_frames", 128'(tid_log.size()), 128'(1));
    if (tid_log.size() > 0) chk("rst_fresh_tid", 128'(tid_log[0]), 128'(0));
    chk_counters("rst_fresh_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
